sub_16bit_seq: RTL

SUB_16BIT_SEQ -- requirements
Module: sub_16bit_seq

---
 rtl/sub_pkg.sv | 30 +++
 rtl/sub_4bit_slice.sv | 40 ++++
 rtl/sub_16bit_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
//------------------------------------------------------------------------------
// Module  : sub_pkg
// Brief   : Shared constants, FSM state type and slice helper for sub_16bit_seq
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package sub_pkg;

  localparam int WIDTH    = 16;
  localparam int SLICE_W  = 4;
  localparam int N_SLICES = WIDTH / SLICE_W;
  localparam int CNT_W    = $clog2(N_SLICES);

  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit offset of slice k within the 16-bit word.
  function automatic logic [3:0] slice_lsb(input logic [CNT_W-1:0] k);
    return {k, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sub_4bit_slice.sv
//------------------------------------------------------------------------------
// Module  : sub_4bit_slice
// Brief   : Combinational 4-bit subtractor slice with borrow lookahead
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sub_4bit_slice
  import sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] d,
  output logic               bout
);

  logic [SLICE_W-1:0] gen;
  logic [SLICE_W-1:0] prop;
  logic [SLICE_W:0]   brw;

  // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
  assign gen  = ~a & b;
  assign prop = ~(a ^ b);

  assign brw[0] = bin;
  assign brw[1] = gen[0] | (prop[0] & bin);
  assign brw[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & bin);
  assign brw[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                | (prop[2] & prop[1] & prop[0] & bin);
  assign brw[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                | (prop[3] & prop[2] & prop[1] & gen[0])
                | (prop[3] & prop[2] & prop[1] & prop[0] & bin);

  assign d    = a ^ b ^ brw[SLICE_W-1:0];
  assign bout = brw[SLICE_W];

endmodule

`default_nettype wire

// File: rtl/sub_16bit_seq.sv
//------------------------------------------------------------------------------
// Module  : sub_16bit_seq
// Brief   : Sequential 16-bit subtractor, one 4-bit slice per cycle.
//           Optional SUB_SIGNED_FLAGS_EN adds ovf/neg result flags.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sub_16bit_seq
  import sub_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1_16bit,
  input  logic [WIDTH-1:0] in2_16bit,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_16bit,
  output logic             bout
`ifdef SUB_SIGNED_FLAGS_EN
  ,
  output logic             ovf,
  output logic             neg
`endif
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               borrow;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [3:0]         lsb;
  logic [SLICE_W-1:0] slice_d;
  logic               slice_bout;

  assign lsb = slice_lsb(cnt);

  sub_4bit_slice u_slice (
    .a    (op_a[lsb +: SLICE_W]),
    .b    (op_b[lsb +: SLICE_W]),
    .bin  (borrow),
    .d    (slice_d),
    .bout (slice_bout)
  );

  // Accumulator with the current slice merged in; on the last slice this is
  // the complete result.
  always_comb begin
    acc_nxt                  = acc;
    acc_nxt[lsb +: SLICE_W]  = slice_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (cnt == LAST_SLICE) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      borrow     <= 1'b0;
      acc        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      diff_16bit <= '0;
      bout       <= 1'b0;
`ifdef SUB_SIGNED_FLAGS_EN
      ovf        <= 1'b0;
      neg        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a   <= in1_16bit;
            op_b   <= in2_16bit;
            borrow <= bin;
            cnt    <= '0;
            acc    <= '0;
          end
        end
        BUSY: begin
          acc    <= acc_nxt;
          borrow <= slice_bout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_SLICE) begin
            diff_16bit <= acc_nxt;
            bout       <= slice_bout;
`ifdef SUB_SIGNED_FLAGS_EN
            ovf        <= (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                          (acc_nxt[WIDTH-1] != op_a[WIDTH-1]);
            neg        <= acc_nxt[WIDTH-1];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
